// File: rtl/audio_fx_path.sv
// Stereo effects path: stage 1 applies the channel mix and latches the gain,
// stage 2 scales by the ramped gain and saturates. Gain ramps per sample.
module audio_fx_path #(
    parameter int DW        = 16,
    parameter int GW        = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic                 VALID,
    input  logic signed [DW-1:0] left_in,
    input  logic signed [DW-1:0] right_in,
    input  logic [1:0]           mode,
    input  logic                 mute,
    input  logic [GW-1:0]        gain,
    output logic signed [DW-1:0] left_out,
    output logic signed [DW-1:0] right_out,
    output logic                 out_valid,
    output logic                 ramp_busy
);

    typedef enum logic [1:0] {
        MIX_PASS      = 2'd0,
        MIX_SWAP      = 2'd1,
        MIX_MONO      = 2'd2,
        MIX_DUAL_LEFT = 2'd3
    } mix_mode_e;

    localparam int PW = DW + GW + 1;
    localparam logic [GW-1:0]        STEP    = GW'(RAMP_STEP);
    localparam logic signed [PW-1:0] SAT_MAX = PW'((longint'(1) << (DW - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    logic [GW-1:0]        cur_gain;
    logic [GW-1:0]        target_now;
    logic [GW-1:0]        next_gain;

    logic signed [DW:0]   sum_lr;
    logic signed [DW-1:0] mix_l;
    logic signed [DW-1:0] mix_r;

    logic                 s1_valid;
    logic signed [DW-1:0] s1_l;
    logic signed [DW-1:0] s1_r;
    logic [GW-1:0]        s1_g;

    // Signed sample times unsigned gain, unity at 2^(GW-1), floor then clamp.
    function automatic logic signed [DW-1:0] scale_sat(
        input logic signed [DW-1:0] x,
        input logic [GW-1:0]        g
    );
        logic signed [PW-1:0] prod;
        prod = $signed({{(GW + 1){x[DW-1]}}, x}) * $signed({{(DW + 1){1'b0}}, g});
        prod = prod >>> (GW - 1);
        if (prod > SAT_MAX) begin
            scale_sat = SAT_MAX[DW-1:0];
        end else if (prod < SAT_MIN) begin
            scale_sat = SAT_MIN[DW-1:0];
        end else begin
            scale_sat = prod[DW-1:0];
        end
    endfunction

    // One step toward the target, landing exactly on it rather than overshooting.
    always_comb begin
        target_now = mute ? '0 : gain;
        next_gain  = cur_gain;
        if (cur_gain < target_now) begin
            if ((target_now - cur_gain) <= STEP) begin
                next_gain = target_now;
            end else begin
                next_gain = cur_gain + STEP;
            end
        end else if (cur_gain > target_now) begin
            if ((cur_gain - target_now) <= STEP) begin
                next_gain = target_now;
            end else begin
                next_gain = cur_gain - STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            cur_gain  <= '0;
            ramp_busy <= 1'b0;
        end else if (VALID) begin
            cur_gain  <= next_gain;
            ramp_busy <= (next_gain != target_now);
        end
    end

    // Mono sum is formed one bit wider so L+R cannot wrap before the halving.
    always_comb begin
        sum_lr = {left_in[DW-1], left_in} + {right_in[DW-1], right_in};
        mix_l  = left_in;
        mix_r  = right_in;
        case (mix_mode_e'(mode))
            MIX_SWAP: begin
                mix_l = right_in;
                mix_r = left_in;
            end
            MIX_MONO: begin
                mix_l = DW'(sum_lr >>> 1);
                mix_r = DW'(sum_lr >>> 1);
            end
            MIX_DUAL_LEFT: begin
                mix_l = left_in;
                mix_r = left_in;
            end
            default: begin
                mix_l = left_in;
                mix_r = right_in;
            end
        endcase
    end

    // The gain captured here is the pre-update value from the strobe cycle.
    always_ff @(posedge clk) begin
        if (RESET) begin
            s1_valid <= 1'b0;
            s1_l     <= '0;
            s1_r     <= '0;
            s1_g     <= '0;
        end else begin
            s1_valid <= VALID;
            if (VALID) begin
                s1_l <= mix_l;
                s1_r <= mix_r;
                s1_g <= cur_gain;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            out_valid <= 1'b0;
            left_out  <= '0;
            right_out <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                left_out  <= scale_sat(s1_l, s1_g);
                right_out <= scale_sat(s1_r, s1_g);
            end
        end
    end

endmodule
